// File: rtl/instruction_serializer_pkg.sv
// Shared types and field layout for the instruction serializer and its FIFO.
package instruction_serializer_pkg;

  localparam int unsigned OPCODE_W       = 3;
  localparam int unsigned OP1_ADDR_W     = 3;
  localparam int unsigned B0_OPCODE_LSB  = 5;
  localparam int unsigned B0_OPNUM_BIT   = 4;
  localparam int unsigned B0_OP2TYPE_BIT = 3;
  localparam int unsigned B0_OP1ADDR_LSB = 0;
  localparam int unsigned INSTR_W        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } ser_state_e;

  function automatic logic [7:0] pack_byte0(
    input logic [OPCODE_W-1:0]   opcode,
    input logic                  operand_num,
    input logic                  operand_2_type,
    input logic [OP1_ADDR_W-1:0] op1_addr
  );
    logic [7:0] b;
    b = '0;
    b[B0_OPCODE_LSB +: OPCODE_W]     = opcode;
    b[B0_OPNUM_BIT]                  = operand_num;
    b[B0_OP2TYPE_BIT]                = operand_2_type;
    b[B0_OP1ADDR_LSB +: OP1_ADDR_W]  = op1_addr;
    return b;
  endfunction

endpackage

// File: rtl/instr_sync_fifo.sv
// Synchronous FIFO for packed 16-bit instructions; pointers wrap modulo FIFO_DEPTH.
module instr_sync_fifo
  import instruction_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [INSTR_W-1:0]            din,
  output logic [INSTR_W-1:0]            dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [INSTR_W-1:0] mem_q [FIFO_DEPTH];
  logic [INSTR_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // Push is gated on full alone, so a pop cannot free a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_serializer.sv
// Buffers instructions and sends each as byte0/byte1 over a valid/ready byte bus.
// Define ISER_SHORT_FORM_EN to send only byte0 for one-operand instructions.
module instruction_serializer
  import instruction_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          In_valid,
  output logic                          In_ready,
  input  logic [OPCODE_W-1:0]           Opcode,
  input  logic                          Operand_num,
  input  logic                          Operand_2_type,
  input  logic [OP1_ADDR_W-1:0]         Operand_1_address,
  input  logic [7:0]                    Operand_2,
  output logic [7:0]                    Data_Bus,
  output logic                          Bus_valid,
  input  logic                          Bus_ready,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
  output logic                          check
);

  ser_state_e         state_q, state_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic [INSTR_W-1:0] fifo_din, fifo_dout;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic               load_next;
  logic [7:0]         byte1;

`ifdef ISER_SHORT_FORM_EN
  assign byte1 = Operand_2;
`else
  assign byte1 = Operand_num ? Operand_2 : 8'h00;
`endif

  assign fifo_din  = {pack_byte0(Opcode, Operand_num, Operand_2_type, Operand_1_address), byte1};
  assign In_ready  = !fifo_full;
  assign fifo_push = In_valid && In_ready;

  instr_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (Fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fifo_pop  = 1'b0;
    load_next = 1'b0;
    unique case (state_q)
      IDLE:    load_next = !fifo_empty;
      SEND_HI: begin
        if (Bus_ready) begin
`ifdef ISER_SHORT_FORM_EN
          if (hold_q[8+B0_OPNUM_BIT]) begin
            state_d = SEND_LO;
          end else begin
            state_d   = IDLE;
            load_next = !fifo_empty;
          end
`else
          state_d = SEND_LO;
`endif
        end
      end
      SEND_LO: begin
        if (Bus_ready) begin
          state_d   = IDLE;
          load_next = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading straight from a completed handshake avoids an idle bubble.
    if (load_next) begin
      fifo_pop = 1'b1;
      hold_d   = fifo_dout;
      state_d  = SEND_HI;
    end
  end

  always_comb begin
    Data_Bus  = 8'h00;
    Bus_valid = 1'b0;
    unique case (state_q)
      SEND_HI: begin
        Data_Bus  = hold_q[15:8];
        Bus_valid = 1'b1;
      end
      SEND_LO: begin
        Data_Bus  = hold_q[7:0];
        Bus_valid = 1'b1;
      end
      default: begin
        Data_Bus  = 8'h00;
        Bus_valid = 1'b0;
      end
    endcase
  end

  assign check = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_instruction_serializer.sv
// Directed bench for instruction_serializer with a byte scoreboard on the output bus.
module tb_instruction_serializer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       In_valid;
  logic       In_ready;
  logic [2:0] Opcode;
  logic       Operand_num;
  logic       Operand_2_type;
  logic [2:0] Operand_1_address;
  logic [7:0] Operand_2;
  logic [7:0] Data_Bus;
  logic       Bus_valid;
  logic       Bus_ready;
  logic [2:0] Fifo_count;
  logic       check;

  int         n_asserts = 0;
  int         n_fail    = 0;
  int         bytes_seen = 0;
  int         valid_cycles = 0;
  int         cyc = 0;
  int         first_v = -1;
  int         last_v = -1;
  logic [7:0] exp_q [$];
  logic [7:0] seen_b [$];

  always #5 CLK = ~CLK;

  instruction_serializer #(
    .FIFO_DEPTH (4)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .In_valid          (In_valid),
    .In_ready          (In_ready),
    .Opcode            (Opcode),
    .Operand_num       (Operand_num),
    .Operand_2_type    (Operand_2_type),
    .Operand_1_address (Operand_1_address),
    .Operand_2         (Operand_2),
    .Data_Bus          (Data_Bus),
    .Bus_valid         (Bus_valid),
    .Bus_ready         (Bus_ready),
    .Fifo_count        (Fifo_count),
    .check             (check)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes the current cycle, then advances to 1 time unit after the next edge.
  task automatic tick();
    if (Bus_valid && Bus_ready) begin
      bytes_seen++;
      seen_b.push_back(Data_Bus);
      if (exp_q.size() == 0) chk("stray_byte", int'(Bus_valid), 0);
      else chk("bus_byte", int'(Data_Bus), int'(exp_q.pop_front()));
    end
    if (Bus_valid) begin
      valid_cycles++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic num, input logic typ,
                           input logic [2:0] addr, input logic [7:0] op2);
    Opcode            = op;
    Operand_num       = num;
    Operand_2_type    = typ;
    Operand_1_address = addr;
    Operand_2         = op2;
    In_valid          = 1'b1;
    exp_q.push_back({op, num, typ, addr});
`ifdef ISER_SHORT_FORM_EN
    if (num) exp_q.push_back(op2);
`else
    exp_q.push_back(num ? op2 : 8'h00);
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0 && !Bus_valid) break;
      tick();
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; In_valid = 1'b0; Bus_ready = 1'b0;
    Opcode = '0; Operand_num = 1'b0; Operand_2_type = 1'b0;
    Operand_1_address = '0; Operand_2 = '0;
    tick();
    tick();
    chk("rst_valid", int'(Bus_valid), 0);
    chk("rst_count", int'(Fifo_count), 0);
    chk("rst_in_ready", int'(In_ready), 1);
    chk("rst_check", int'(check), 0);
    chk("rst_data", int'(Data_Bus), 0);
    RESET = 1'b0;

    // Single instruction, minimum latency: byte0 = {101,1,1,010} = 8'hBA
    Bus_ready = 1'b1;
    set_instr(3'b101, 1'b1, 1'b1, 3'b010, 8'h3C);
    tick();
    In_valid = 1'b0;
    chk("lat_n1_valid", int'(Bus_valid), 0);
    chk("lat_n1_count", int'(Fifo_count), 1);
    tick();
    chk("lat_n2_valid", int'(Bus_valid), 1);
    chk("lat_n2_byte0", int'(Data_Bus), 'hBA);
    chk("lat_n2_check", int'(check), 1);
    tick();
    chk("lat_n3_valid", int'(Bus_valid), 1);
    chk("lat_n3_byte1", int'(Data_Bus), 'h3C);
    tick();
    chk("lat_idle_valid", int'(Bus_valid), 0);
    chk("lat_idle_data", int'(Data_Bus), 0);
    chk("lat_idle_check", int'(check), 0);

    // Stall in SEND_LO: byte0 = {011,1,0,101} = 8'h75, byte1 = 8'h07
    set_instr(3'b011, 1'b1, 1'b0, 3'b101, 8'h07);
    tick();
    In_valid = 1'b0;
    tick();
    chk("stall_byte0", int'(Data_Bus), 'h75);
    tick();
    Bus_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("stall_hold_data", int'(Data_Bus), 'h07);
      chk("stall_hold_valid", int'(Bus_valid), 1);
      tick();
    end
    Bus_ready = 1'b1;
    chk("stall_release_data", int'(Data_Bus), 'h07);
    chk("stall_release_valid", int'(Bus_valid), 1);
    tick();
    chk("stall_done_valid", int'(Bus_valid), 0);

    // Back-to-back fill with the bus stalled; one entry sits in the holding register
    Bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_instr(3'(i), 1'b1, 1'(i), 3'(i + 1), 8'(8'h10 + i));
      chk("fill_in_ready", int'(In_ready), 1);
      tick();
      if (i == 3) chk("fill_count_after4", int'(Fifo_count), 3);
    end
    chk("fill_count_full", int'(Fifo_count), 4);
    chk("fill_in_ready_full", int'(In_ready), 0);
    set_instr(3'b111, 1'b1, 1'b1, 3'b111, 8'hEE);
    tick();
    chk("full_refuse_count", int'(Fifo_count), 4);
    chk("full_refuse_ready", int'(In_ready), 0);
    Bus_ready = 1'b1;
    tick();
    chk("full_mid_count", int'(Fifo_count), 4);
    chk("full_mid_ready", int'(In_ready), 0);
    tick();
    chk("full_freed_count", int'(Fifo_count), 3);
    chk("full_freed_ready", int'(In_ready), 1);
    tick();
    In_valid = 1'b0;
    chk("full_accept_count", int'(Fifo_count), 4);
    drain();

    // Three-instruction stream with the bus always ready
    valid_cycles = 0;
    first_v = -1;
    set_instr(3'b001, 1'b1, 1'b0, 3'b110, 8'hA1);
    tick();
    set_instr(3'b100, 1'b1, 1'b1, 3'b011, 8'hB2);
    tick();
    set_instr(3'b110, 1'b1, 1'b0, 3'b000, 8'hC3);
    tick();
    In_valid = 1'b0;
    drain();
    chk("stream_valid_cycles", valid_cycles, 6);
    chk("stream_span", last_v - first_v + 1, 6);

    // Reset while in SEND_LO with two entries queued
    Bus_ready = 1'b0;
    set_instr(3'b010, 1'b1, 1'b1, 3'b100, 8'h5A);
    tick();
    set_instr(3'b011, 1'b1, 1'b0, 3'b101, 8'h6B);
    tick();
    set_instr(3'b100, 1'b1, 1'b1, 3'b110, 8'h7C);
    tick();
    In_valid = 1'b0;
    chk("rst2_queued", int'(Fifo_count), 2);
    Bus_ready = 1'b1;
    tick();
    Bus_ready = 1'b0;
    chk("rst2_lo_valid", int'(Bus_valid), 1);
    chk("rst2_lo_data", int'(Data_Bus), 'h5A);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_q.delete();
    chk("rst2_valid", int'(Bus_valid), 0);
    chk("rst2_count", int'(Fifo_count), 0);
    chk("rst2_in_ready", int'(In_ready), 1);
    chk("rst2_check", int'(check), 0);
    chk("rst2_data", int'(Data_Bus), 0);
    Bus_ready = 1'b1;
    bytes_seen = 0;
    repeat (10) tick();
    chk("rst2_no_stale", bytes_seen, 0);

    // One-operand then two-operand: byte0s are 8'h43 and 8'hD1
    bytes_seen = 0;
    seen_b.delete();
    set_instr(3'b010, 1'b0, 1'b0, 3'b011, 8'h55);
    tick();
    set_instr(3'b110, 1'b1, 1'b0, 3'b001, 8'h99);
    tick();
    In_valid = 1'b0;
    drain();
`ifdef ISER_SHORT_FORM_EN
    chk("form_byte_count", bytes_seen, 3);
    chk("form_second_byte", (seen_b.size() > 1) ? int'(seen_b[1]) : -1, 'hD1);
`else
    chk("form_byte_count", bytes_seen, 4);
    chk("form_second_byte", (seen_b.size() > 1) ? int'(seen_b[1]) : -1, 'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
